// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage program-counter unit.
// Next-PC select codes and the default reset vector.
package pc_pkg;

   localparam int unsigned DEFAULT_RESET_VEC = 0;

   localparam logic [2:0] SEL_SEQ   = 3'd0;
   localparam logic [2:0] SEL_REDIR = 3'd1;
   localparam logic [2:0] SEL_CALL  = 3'd2;
   localparam logic [2:0] SEL_RET   = 3'd3;
   localparam logic [2:0] SEL_HOLD  = 3'd4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Top is valid the cycle after a push; callers must not pop when empty.
module pc_ras #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic [WIDTH-1:0] top_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The pointer wraps naturally because DEPTH is a power of two, so a full
   // push simply lands on the oldest slot while the count saturates.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push_i) begin
         ptr_d = ptr_q + PTR_W'(1);
         if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_i) begin
         ptr_d = ptr_q - PTR_W'(1);
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         if (push_i) mem_q[ptr_d] <= push_data_i;
      end
   end

   assign top_o   = mem_q[ptr_q];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with redirect > stall > ret > call > sequential priority.
// Next PC appears one cycle after its inputs; stall holds PC and RAS, redirect overrides stall.
module pc_unit
   import pc_pkg::*;
#(
   parameter int                WIDTH     = 14,
   parameter int                INC       = 1,
   parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(DEFAULT_RESET_VEC),
   parameter int                RAS_DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_stall,
   input  logic             i_redirect,
   input  logic [WIDTH-1:0] i_redirect_addr,
   input  logic             i_call,
   input  logic [WIDTH-1:0] i_call_target,
   input  logic             i_ret,
   output logic [WIDTH-1:0] o_pc,
   output logic             o_ras_empty,
   output logic             o_ras_full,
   output logic             o_ras_underflow
);

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   logic [WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
   logic             uf_q, uf_d;
   logic [2:0]       sel;

   assign pc_inc = pc_q + INC_W;

   // An empty ret falls through to sequential fetch and raises the underflow flag.
   always_comb begin
      sel  = SEL_SEQ;
      uf_d = 1'b0;
      if (i_redirect)       sel = SEL_REDIR;
      else if (i_stall)     sel = SEL_HOLD;
      else if (i_ret) begin
         if (o_ras_empty)   uf_d = 1'b1;
         else               sel  = SEL_RET;
      end
      else if (i_call)      sel = SEL_CALL;
   end

   always_comb begin
      case (sel)
         SEL_REDIR: pc_d = i_redirect_addr;
         SEL_HOLD:  pc_d = pc_q;
         SEL_RET:   pc_d = ras_top;
         SEL_CALL:  pc_d = i_call_target;
         default:   pc_d = pc_inc;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q <= RESET_VEC;
         uf_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         uf_q <= uf_d;
      end
   end

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .push_i      (sel == SEL_CALL),
      .pop_i       (sel == SEL_RET),
      .push_data_i (pc_inc),
      .top_o       (ras_top),
      .empty_o     (o_ras_empty),
      .full_o      (o_ras_full)
   );

   assign o_pc            = pc_q;
   assign o_ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand-written corner sequences,
// then random stimulus against a queue-based reference model.
module tb_pc_unit;

   localparam int W = 14;
   localparam int D = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_stall, i_redirect, i_call, i_ret;
   logic [W-1:0]  i_redirect_addr, i_call_target;
   logic [W-1:0]  o_pc;
   logic          o_ras_empty, o_ras_full, o_ras_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   pc_unit #(.WIDTH(W), .INC(1), .RESET_VEC('0), .RAS_DEPTH(D)) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_stall         (i_stall),
      .i_redirect      (i_redirect),
      .i_redirect_addr (i_redirect_addr),
      .i_call          (i_call),
      .i_call_target   (i_call_target),
      .i_ret           (i_ret),
      .o_pc            (o_pc),
      .o_ras_empty     (o_ras_empty),
      .o_ras_full      (o_ras_full),
      .o_ras_underflow (o_ras_underflow)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic         stall;
      logic         redir;
      logic [W-1:0] raddr;
      logic         call;
      logic [W-1:0] ctgt;
      logic         ret;
      logic [W-1:0] epc;
      logic         eempty;
      logic         efull;
      logic         euf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(logic st, logic rd, int ra, logic cl, int ct, logic rt,
                                int pc, logic em, logic fu, logic uf);
      vec_t v;
      v.stall = st; v.redir = rd; v.raddr = W'(ra);
      v.call = cl; v.ctgt = W'(ct); v.ret = rt;
      v.epc = W'(pc); v.eempty = em; v.efull = fu; v.euf = uf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic rd, input logic [W-1:0] ra,
                        input logic cl, input logic [W-1:0] ct, input logic rt);
      i_stall = st; i_redirect = rd; i_redirect_addr = ra;
      i_call = cl; i_call_target = ct; i_ret = rt;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      idle_inputs();
      i_rst_n = 1'b0;
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic chk_all(input string tag, input logic [W-1:0] pc, input logic em,
                          input logic fu, input logic uf);
      chk({tag, ".pc"},    32'(o_pc),            32'(pc));
      chk({tag, ".empty"}, 32'(o_ras_empty),     32'(em));
      chk({tag, ".full"},  32'(o_ras_full),      32'(fu));
      chk({tag, ".uf"},    32'(o_ras_underflow), 32'(uf));
   endtask

   // Reference model state: the RAS as a bounded queue, newest at the back.
   logic [W-1:0] m_pc;
   logic         m_uf;
   logic [W-1:0] m_stack[$];

   task automatic model_step(input logic st, input logic rd, input logic [W-1:0] ra,
                             input logic cl, input logic [W-1:0] ct, input logic rt);
      logic [W-1:0] nxt;
      nxt  = m_pc + W'(1);
      m_uf = 1'b0;
      if (rd) m_pc = ra;
      else if (st) m_pc = m_pc;
      else if (rt) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else begin m_pc = nxt; m_uf = 1'b1; end
      end else if (cl) begin
         if (m_stack.size() == D) void'(m_stack.pop_front());
         m_stack.push_back(nxt);
         m_pc = ct;
      end else m_pc = nxt;
   endtask

   initial begin
      i_rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      chk_all("reset", '0, 1'b1, 1'b0, 1'b0);
      i_rst_n = 1'b1;

      //           st rd raddr  cl ctgt   rt  pc     em fu uf
      vecs.push_back(mkv(0, 0, 0,     0, 0,     0, 1,     1, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     0, 2,     1, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     0, 3,     1, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     0, 4,     1, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     0, 5,     1, 0, 0));
      vecs.push_back(mkv(1, 0, 0,     0, 0,     1, 5,     1, 0, 0));
      vecs.push_back(mkv(1, 0, 0,     1, 'h77,  0, 5,     1, 0, 0));
      vecs.push_back(mkv(1, 1, 'h100, 0, 0,     0, 'h100, 1, 0, 0));
      vecs.push_back(mkv(0, 1, 'h10,  0, 0,     0, 'h10,  1, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     1, 'h200, 0, 'h200, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     0, 'h201, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     1, 'h300, 0, 'h300, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     1, 'h202, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     1, 'h11,  1, 0, 0));
      vecs.push_back(mkv(0, 1, 'h3F,  0, 0,     0, 'h3F,  1, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     1, 'h500, 0, 'h500, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     1, 'h600, 1, 'h40,  1, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     1, 'h700, 0, 'h700, 0, 0, 0));
      vecs.push_back(mkv(0, 1, 'h80,  0, 0,     1, 'h80,  0, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     1, 'h41,  1, 0, 0));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     1, 'h42,  1, 0, 1));
      vecs.push_back(mkv(0, 0, 0,     0, 0,     0, 'h43,  1, 0, 0));
      vecs.push_back(mkv(1, 0, 0,     0, 0,     1, 'h43,  1, 0, 0));
      vecs.push_back(mkv(0, 1, 'h50,  0, 0,     1, 'h50,  1, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].stall, vecs[i].redir, vecs[i].raddr,
               vecs[i].call, vecs[i].ctgt, vecs[i].ret);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].epc, vecs[i].eempty,
                 vecs[i].efull, vecs[i].euf);
      end

      // Asynchronous reset in the middle of a cycle, checked before the next edge.
      idle_inputs();
      drive(1'b0, 1'b0, '0, 1'b1, W'('h123), 1'b0);
      tick();
      idle_inputs();
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_all("async_rst", '0, 1'b1, 1'b0, 1'b0);
      tick();
      i_rst_n = 1'b1;

      // Overflow: five calls from pcs 1..5 into a four-deep stack.
      tick();
      chk("ovf.start", 32'(o_pc), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, W'(k + 1), 1'b0);
         tick();
         chk($sformatf("ovf.call%0d", k), 32'(o_pc), 32'(k + 1));
      end
      chk("ovf.full", 32'(o_ras_full), 32'd1);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
         tick();
         chk($sformatf("ovf.ret%0d", k), 32'(o_pc), 32'(6 - k));
      end
      chk("ovf.empty", 32'(o_ras_empty), 32'd1);
      tick();
      chk_all("ovf.under", W'(4), 1'b1, 1'b0, 1'b1);
      idle_inputs();
      tick();
      chk_all("ovf.after", W'(5), 1'b1, 1'b0, 1'b0);

      // Wrap-around of the PC and of the pushed return address.
      drive(1'b0, 1'b1, W'('h3FFF), 1'b0, '0, 1'b0);
      tick();
      idle_inputs();
      tick();
      chk("wrap.seq", 32'(o_pc), 32'd0);
      drive(1'b0, 1'b1, W'('h3FFF), 1'b0, '0, 1'b0);
      tick();
      drive(1'b0, 1'b0, '0, 1'b1, W'('h123), 1'b0);
      tick();
      chk("wrap.call", 32'(o_pc), 32'h123);
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      tick();
      chk_all("wrap.ret", '0, 1'b1, 1'b0, 1'b0);

      // Random traffic against the reference model.
      do_reset();
      m_pc = '0;
      m_uf = 1'b0;
      m_stack.delete();
      for (int n = 0; n < 400; n++) begin
         logic st, rd, cl, rt;
         logic [W-1:0] ra, ct;
         rd = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 5) == 0);
         cl = ($urandom_range(0, 2) == 0);
         rt = ($urandom_range(0, 3) == 0);
         ra = W'($urandom);
         ct = W'($urandom);
         if ($urandom_range(0, 15) == 0) ct = W'('h3FFF);
         drive(st, rd, ra, cl, ct, rt);
         model_step(st, rd, ra, cl, ct, rt);
         tick();
         chk_all($sformatf("rnd%0d", n), m_pc, (m_stack.size() == 0),
                 (m_stack.size() == D), m_uf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
